id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage ARM pipeline; consumes PC/instruction from the fetch stage's IF/ID register.
//  Holds the 15-entry register file (R0-R14) and decodes data-proc/LDR/STR/B.
//  Evaluates cond[31:28] vs NZCV, detects RAW hazards and registers results into ID/EX.
// PARAMETERS
//  WIDTH   32  datapath width (PC, register values)
//  NREGS   15  architectural registers in file (R0-R14)
// PORTS
//  clk         in   1   single clock, all state on posedge
//  rst         in   1   synchronous, active-high reset
//  flush       in   1   branch taken in EXE: squash current decode
//  PC          in   32  PC+4 from IF/ID register
//  instruction in   32  instruction from IF/ID register
//  status      in   4   NZCV from status register
//  wbEn        in   1   writeback enable from WB stage
//  wbDest      in   4   writeback register index
//  wbValue     in   32  writeback data
//  exeWbEn     in   1   EXE-stage instruction writes a register
//  exeDest     in   4   EXE-stage destination
//  memWbEn     in   1   MEM-stage instruction writes a register
//  memDest     in   4   MEM-stage destination
//  hazard      out  1   combinational stall request (fetch freezes PC and IF/ID)
//  idPC        out  32  registered PC
//  valRn/valRm out  32  registered operand values (valRm = Rd for STR)
//  imm         out  1   I bit; shiftOperand out 12 = instr[11:0]; signedImm24 out 24 = instr[23:0]
//  dest        out  4   instr[15:12]; src1/src2 out 4 each: Rn and Rm-or-Rd indices for forwarding
//  exeCmd      out  4   ALU command; memRead/memWrite/wbEnOut/b/s out 1 each: control
// BEHAVIOUR
//  - Fields: mode=instr[27:26], I=[25], op=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].
//  - exeCmd (mode 00): MOV1101->0001 MVN1111->1001 ADD0100->0010 ADC0101->0011 SUB0010->0100
//    SBC0110->0101 AND0000->0110 ORR1100->0111 EOR0001->1000 CMP1010->0100 TST1000->0110; others->0000, wbEn 0.
//  - wbEn=1 for all data-proc except CMP/TST; s=S. Mode 01: exeCmd 0010; S=1 LDR (memRead, wbEn);
//    S=0 STR (memWrite, no wbEn); s=0. Mode 10: b=1, no other control. Mode 11: all control 0.
//  - Cond EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL per ARM; code 1111 = never. Fail -> all control 0 (bubble).
//  - Regfile: write on posedge when wbEn; wbDest=15 ignored. Read comb.; if wbEn & addr==wbDest return wbValue (bypass).
//    Reading index 15 returns PC input. rst clears R0-R14 to 0.
//  - src1=Rn; src2=Rd if STR else Rm. usesRn: mode 00 except MOV/MVN, or mode 01. usesSrc2: STR, or mode00 & I=0.
//  - hazard = cond pass & [(usesRn & ((exeWbEn & Rn==exeDest) | (memWbEn & Rn==memDest)))
//    | (usesSrc2 & same for src2)]. Branches never raise hazard.
//  - ID/EX register, priority rst > flush > hazard > load: rst and flush clear every output to 0;
//    hazard loads bubble (control 0, data don't-care but zeroed); else load decoded values. Latency 1 cycle.
//  - Flush and hazard same cycle: flush wins (bubble). wbDest collision with current read: bypassed value used.
// TESTING
//  - rst=1 for 2 cycles -> all outputs 0; then read R3 -> 0.
//  - wbEn=1 wbDest=2 wbValue=0x55 while decoding ADD R1,R2,R3 (0xE0821003) -> next cycle valRn=0x55, exeCmd=0010, wbEnOut=1, dest=1.
//  - ADDEQ with status Z=0 -> next cycle control all 0; with Z=1 -> wbEnOut=1.
//  - exeWbEn=1 exeDest=2, decode SUB R4,R2,#1 -> hazard=1, ID/EX bubble; MOV R4,#1 (0xE3A04001) instead -> hazard=0.
//  - STR R5,[R1,#4] (0xE5815004) -> memWrite=1, wbEnOut=0, src2=5, valRm=R5, exeCmd=0010.
//  - B (0xEA000002) with flush=1 same cycle -> ID/EX all 0; without flush -> b=1, signedImm24=0x000002.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: register file, instruction decode, condition check,
// RAW hazard detection and the ID/EX pipeline register.
// Ports:
//   in  : clk, rst, flush, PC, instruction, status,
//         wbEn/wbDest/wbValue, exeWbEn/exeDest, memWbEn/memDest
//   out : hazard, idPC, valRn, valRm, imm, shiftOperand, signedImm24,
//         dest, src1, src2, exeCmd, memRead, memWrite, wbEnOut, b, s
module id_stage #(
   parameter int WIDTH = 32,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] PC,
   input  logic [31:0]      instruction,
   input  logic [3:0]       status,
   input  logic             wbEn,
   input  logic [3:0]       wbDest,
   input  logic [WIDTH-1:0] wbValue,
   input  logic             exeWbEn,
   input  logic [3:0]       exeDest,
   input  logic             memWbEn,
   input  logic [3:0]       memDest,
   output logic             hazard,
   output logic [WIDTH-1:0] idPC,
   output logic [WIDTH-1:0] valRn,
   output logic [WIDTH-1:0] valRm,
   output logic             imm,
   output logic [11:0]      shiftOperand,
   output logic [23:0]      signedImm24,
   output logic [3:0]       dest,
   output logic [3:0]       src1,
   output logic [3:0]       src2,
   output logic [3:0]       exeCmd,
   output logic             memRead,
   output logic             memWrite,
   output logic             wbEnOut,
   output logic             b,
   output logic             s
);

   // instruction fields
   logic [3:0] cond_w;
   logic [1:0] mode_w;
   logic       i_w;
   logic [3:0] op_w;
   logic       s_w;
   logic [3:0] rn_w;
   logic [3:0] rd_w;
   logic [3:0] rm_w;

   assign cond_w = instruction[31:28];
   assign mode_w = instruction[27:26];
   assign i_w    = instruction[25];
   assign op_w   = instruction[24:21];
   assign s_w    = instruction[20];
   assign rn_w   = instruction[19:16];
   assign rd_w   = instruction[15:12];
   assign rm_w   = instruction[3:0];

   // ---------------- register file ----------------
   logic [WIDTH-1:0] rf_q [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wbEn && (int'(wbDest) < NREGS)) begin
         rf_q[wbDest] <= wbValue;
      end
   end

   // Index 15 reads the incoming PC; a same-cycle writeback is bypassed.
   function automatic logic [WIDTH-1:0] rf_read(input logic [3:0] idx);
      logic [WIDTH-1:0] v;
      if (int'(idx) >= NREGS) begin
         v = PC;
      end else if (wbEn && (idx == wbDest)) begin
         v = wbValue;
      end else begin
         v = rf_q[idx];
      end
      return v;
   endfunction

   // ---------------- condition check ----------------
   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_pass;

   assign {flag_n, flag_z, flag_c, flag_v} = status;

   always_comb begin
      cond_pass = 1'b0;
      case (cond_w)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = !flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = !flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = !flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = !flag_v;
         4'b1000: cond_pass = flag_c && !flag_z;
         4'b1001: cond_pass = !flag_c || flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
         4'b1101: cond_pass = flag_z || (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // ---------------- control decode ----------------
   logic [3:0] cmd_w;
   logic       mem_rd_w, mem_wr_w, wb_w, b_w, s_ctl_w;
   logic       is_str;

   always_comb begin
      cmd_w    = 4'b0000;
      mem_rd_w = 1'b0;
      mem_wr_w = 1'b0;
      wb_w     = 1'b0;
      b_w      = 1'b0;
      s_ctl_w  = 1'b0;
      case (mode_w)
         2'b00: begin
            s_ctl_w = s_w;
            wb_w    = 1'b1;
            case (op_w)
               4'b1101: cmd_w = 4'b0001;
               4'b1111: cmd_w = 4'b1001;
               4'b0100: cmd_w = 4'b0010;
               4'b0101: cmd_w = 4'b0011;
               4'b0010: cmd_w = 4'b0100;
               4'b0110: cmd_w = 4'b0101;
               4'b0000: cmd_w = 4'b0110;
               4'b1100: cmd_w = 4'b0111;
               4'b0001: cmd_w = 4'b1000;
               4'b1010: begin
                  cmd_w = 4'b0100;
                  wb_w  = 1'b0;
               end
               4'b1000: begin
                  cmd_w = 4'b0110;
                  wb_w  = 1'b0;
               end
               default: begin
                  cmd_w = 4'b0000;
                  wb_w  = 1'b0;
               end
            endcase
         end
         2'b01: begin
            cmd_w    = 4'b0010;
            mem_rd_w = s_w;
            mem_wr_w = !s_w;
            wb_w     = s_w;
         end
         2'b10: b_w = 1'b1;
         default: ;
      endcase
   end

   assign is_str = (mode_w == 2'b01) && !s_w;

   // ---------------- hazard detection ----------------
   logic [3:0] src2_w;
   logic       uses_rn, uses_src2;
   logic       rn_hit, src2_hit;

   assign src2_w = is_str ? rd_w : rm_w;

   // MOV/MVN ignore Rn; branches use no registers at all.
   assign uses_rn = ((mode_w == 2'b00) &&
                     (op_w != 4'b1101) && (op_w != 4'b1111))
                    || (mode_w == 2'b01);
   assign uses_src2 = is_str || ((mode_w == 2'b00) && !i_w);

   assign rn_hit = (exeWbEn && (rn_w == exeDest))
                   || (memWbEn && (rn_w == memDest));
   assign src2_hit = (exeWbEn && (src2_w == exeDest))
                     || (memWbEn && (src2_w == memDest));

   assign hazard = cond_pass &&
                   ((uses_rn && rn_hit) || (uses_src2 && src2_hit));

   // ---------------- ID/EX register ----------------
   logic [WIDTH-1:0] pc_q, rn_q, rm_q;
   logic [WIDTH-1:0] pc_d, rn_d, rm_d;
   logic [11:0]      sh_q, sh_d;
   logic [23:0]      si_q, si_d;
   logic [3:0]       dest_q, src1_q, src2_q, cmd_q;
   logic [3:0]       dest_d, src1_d, src2_d, cmd_d;
   logic             imm_q, mrd_q, mwr_q, wb_q, b_q, s_q;
   logic             imm_d, mrd_d, mwr_d, wb_d, b_d, s_d;
   logic             ctl_en;

   // failed condition leaves data intact but drops every control bit
   assign ctl_en = cond_pass;

   always_comb begin
      pc_d   = '0;
      rn_d   = '0;
      rm_d   = '0;
      sh_d   = '0;
      si_d   = '0;
      dest_d = '0;
      src1_d = '0;
      src2_d = '0;
      cmd_d  = '0;
      imm_d  = 1'b0;
      mrd_d  = 1'b0;
      mwr_d  = 1'b0;
      wb_d   = 1'b0;
      b_d    = 1'b0;
      s_d    = 1'b0;
      if (!flush && !hazard) begin
         pc_d   = PC;
         rn_d   = rf_read(rn_w);
         rm_d   = rf_read(src2_w);
         sh_d   = instruction[11:0];
         si_d   = instruction[23:0];
         dest_d = rd_w;
         src1_d = rn_w;
         src2_d = src2_w;
         imm_d  = i_w;
         cmd_d  = ctl_en ? cmd_w : 4'b0000;
         mrd_d  = ctl_en && mem_rd_w;
         mwr_d  = ctl_en && mem_wr_w;
         wb_d   = ctl_en && wb_w;
         b_d    = ctl_en && b_w;
         s_d    = ctl_en && s_ctl_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         rn_q   <= '0;
         rm_q   <= '0;
         sh_q   <= '0;
         si_q   <= '0;
         dest_q <= '0;
         src1_q <= '0;
         src2_q <= '0;
         cmd_q  <= '0;
         imm_q  <= 1'b0;
         mrd_q  <= 1'b0;
         mwr_q  <= 1'b0;
         wb_q   <= 1'b0;
         b_q    <= 1'b0;
         s_q    <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         rn_q   <= rn_d;
         rm_q   <= rm_d;
         sh_q   <= sh_d;
         si_q   <= si_d;
         dest_q <= dest_d;
         src1_q <= src1_d;
         src2_q <= src2_d;
         cmd_q  <= cmd_d;
         imm_q  <= imm_d;
         mrd_q  <= mrd_d;
         mwr_q  <= mwr_d;
         wb_q   <= wb_d;
         b_q    <= b_d;
         s_q    <= s_d;
      end
   end

   assign idPC         = pc_q;
   assign valRn        = rn_q;
   assign valRm        = rm_q;
   assign shiftOperand = sh_q;
   assign signedImm24  = si_q;
   assign dest         = dest_q;
   assign src1         = src1_q;
   assign src2         = src2_q;
   assign exeCmd       = cmd_q;
   assign imm          = imm_q;
   assign memRead      = mrd_q;
   assign memWrite     = mwr_q;
   assign wbEnOut      = wb_q;
   assign b            = b_q;
   assign s            = s_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, condition, hazard,
// bypass, flush and ID/EX register behaviour.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [31:0] PC, instruction;
   logic [3:0]  status;
   logic        wbEn;
   logic [3:0]  wbDest;
   logic [31:0] wbValue;
   logic        exeWbEn, memWbEn;
   logic [3:0]  exeDest, memDest;
   logic        hazard;
   logic [31:0] idPC, valRn, valRm;
   logic        imm;
   logic [11:0] shiftOperand;
   logic [23:0] signedImm24;
   logic [3:0]  dest, src1, src2, exeCmd;
   logic        memRead, memWrite, wbEnOut, b, s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .PC(PC),
      .instruction(instruction), .status(status),
      .wbEn(wbEn), .wbDest(wbDest), .wbValue(wbValue),
      .exeWbEn(exeWbEn), .exeDest(exeDest),
      .memWbEn(memWbEn), .memDest(memDest),
      .hazard(hazard), .idPC(idPC), .valRn(valRn), .valRm(valRm),
      .imm(imm), .shiftOperand(shiftOperand),
      .signedImm24(signedImm24), .dest(dest), .src1(src1),
      .src2(src2), .exeCmd(exeCmd), .memRead(memRead),
      .memWrite(memWrite), .wbEnOut(wbEnOut), .b(b), .s(s)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ctl();
      return {exeCmd, memRead, memWrite, wbEnOut, b};
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; PC = 32'h0; instruction = 32'h0;
      status = 4'h0; wbEn = 1'b0; wbDest = 4'h0; wbValue = 32'h0;
      exeWbEn = 1'b0; exeDest = 4'h0; memWbEn = 1'b0; memDest = 4'h0;
      tick();
      tick();
      chk("rst_idPC", idPC, 32'h0);
      chk("rst_valRn", valRn, 32'h0);
      chk("rst_ctl", {24'h0, ctl()}, 32'h0);
      chk("rst_s", {31'h0, s}, 32'h0);
      rst = 1'b0;

      // ADD R1,R2,R3 with R2 written back in the same cycle
      PC = 32'h104; instruction = 32'hE0821003;
      wbEn = 1'b1; wbDest = 4'd2; wbValue = 32'h55;
      #1 chk("add_hz", {31'h0, hazard}, 32'h0);
      tick();
      chk("add_valRn", valRn, 32'h55);
      chk("add_valRm_R3", valRm, 32'h0);
      chk("add_cmd", {28'h0, exeCmd}, 32'h2);
      chk("add_wb", {31'h0, wbEnOut}, 32'h1);
      chk("add_dest", {28'h0, dest}, 32'h1);
      chk("add_src", {24'h0, src1, src2}, 32'h23);
      chk("add_pc", idPC, 32'h104);
      wbEn = 1'b0;

      // ADDEQ: Z=0 fails, Z=1 passes; R2 now held in the file
      instruction = 32'h00821003; status = 4'b0000;
      tick();
      chk("addeq_fail_ctl", {24'h0, ctl()}, 32'h0);
      chk("addeq_fail_rn", valRn, 32'h55);
      status = 4'b0100;
      tick();
      chk("addeq_pass_wb", {31'h0, wbEnOut}, 32'h1);
      chk("addeq_pass_cmd", {28'h0, exeCmd}, 32'h2);
      status = 4'b0000;

      // never condition
      instruction = 32'hF0821003;
      tick();
      chk("nv_ctl", {24'h0, ctl()}, 32'h0);

      // GE with N=1 V=1 passes; SUBS sets s
      instruction = 32'hA0521003; status = 4'b1001;
      tick();
      chk("ge_cmd", {28'h0, exeCmd}, 32'h4);
      chk("ge_s", {31'h0, s}, 32'h1);
      status = 4'b0000;

      // RAW hazard from EXE on Rn
      exeWbEn = 1'b1; exeDest = 4'd2; PC = 32'h200;
      instruction = 32'hE2424001;
      #1 chk("sub_hz", {31'h0, hazard}, 32'h1);
      tick();
      chk("sub_bub_ctl", {24'h0, ctl()}, 32'h0);
      chk("sub_bub_pc", idPC, 32'h0);
      chk("sub_bub_rn", valRn, 32'h0);

      // MOV ignores Rn: no hazard
      instruction = 32'hE3A04001;
      #1 chk("mov_hz", {31'h0, hazard}, 32'h0);
      tick();
      chk("mov_cmd", {28'h0, exeCmd}, 32'h1);
      chk("mov_wb", {31'h0, wbEnOut}, 32'h1);
      chk("mov_imm", {19'h0, imm, shiftOperand}, 32'h1001);
      chk("mov_dest", {28'h0, dest}, 32'h4);
      exeWbEn = 1'b0;

      // MEM-stage hazard on Rm
      memWbEn = 1'b1; memDest = 4'd3; instruction = 32'hE0821003;
      #1 chk("mem_hz", {31'h0, hazard}, 32'h1);
      // flush and hazard together: flush bubble
      flush = 1'b1;
      tick();
      chk("fl_hz_ctl", {24'h0, ctl()}, 32'h0);
      flush = 1'b0; memWbEn = 1'b0;

      // load R5 via writeback while decoding a mode-11 no-op
      instruction = 32'hEC000000; wbEn = 1'b1;
      wbDest = 4'd5; wbValue = 32'hDEAD;
      tick();
      chk("m11_ctl", {24'h0, ctl()}, 32'h0);
      wbEn = 1'b0;

      // STR R5,[R1,#4]
      instruction = 32'hE5815004;
      tick();
      chk("str_ctl", {24'h0, ctl()}, 32'h24);
      chk("str_src2", {28'h0, src2}, 32'h5);
      chk("str_valRm", valRm, 32'hDEAD);

      // LDR R5,[R1,#4]
      instruction = 32'hE5915004;
      tick();
      chk("ldr_ctl", {24'h0, ctl()}, 32'h2A);
      chk("ldr_src2", {28'h0, src2}, 32'h4);

      // R15 read returns PC; wbDest=15 is not bypassed into it
      PC = 32'h300; instruction = 32'hE08F1003;
      wbEn = 1'b1; wbDest = 4'd15; wbValue = 32'h99;
      tick();
      chk("r15_rn", valRn, 32'h300);
      wbEn = 1'b0;

      // branch with flush, then without; hazard never raised
      instruction = 32'hEA000002; flush = 1'b1;
      exeWbEn = 1'b1; exeDest = 4'd0;
      #1 chk("b_hz", {31'h0, hazard}, 32'h0);
      tick();
      chk("bfl_b", {31'h0, b}, 32'h0);
      chk("bfl_si", {8'h0, signedImm24}, 32'h0);
      chk("bfl_pc", idPC, 32'h0);
      flush = 1'b0;
      tick();
      chk("b_ctl", {24'h0, ctl()}, 32'h1);
      chk("b_si", {8'h0, signedImm24}, 32'h2);
      exeWbEn = 1'b0;

      // reset again clears state and regfile
      rst = 1'b1;
      tick();
      chk("rst2_ctl", {24'h0, ctl()}, 32'h0);
      rst = 1'b0;
      instruction = 32'hE5815004;
      tick();
      chk("rst2_R5", valRm, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
